// File: rtl/divider_signed_param_if.sv
// divider_signed_param_if: start/finish handshake and operand/result bus for the signed divider
interface divider_signed_param_if #(
    parameter int WIDTH = 21
);
    logic             open;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             finish;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_zero;
    logic             ovf;
    modport master (
        output open, dividend, divisor,
        input  busy, finish, quotient, remainder, div_zero, ovf
    );
    modport slave (
        input  open, dividend, divisor,
        output busy, finish, quotient, remainder, div_zero, ovf
    );
endinterface

// File: rtl/divider_signed_param.sv
// divider_signed_param: iterative radix-2 restoring signed divider with optional fraction bits
module divider_signed_param #(
    parameter int WIDTH     = 21,
    parameter int FRAC_BITS = 0
) (
    input logic                 clk,
    input logic                 rst,
    divider_signed_param_if.slave bus
);
    localparam int N  = WIDTH + FRAC_BITS;
    localparam int CW = $clog2(N);
    localparam logic [WIDTH-1:0] Q_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] Q_MIN = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [N:0]       LIM   = (N+1)'(Q_MIN);
    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
    state_t           state;
    logic             open_d;
    logic             sign_dvd;
    logic             sign_dvs;
    logic             zero;
    logic [WIDTH-1:0] dvd_raw;
    logic [WIDTH-1:0] dvs;
    logic [N-1:0]     acc;
    logic [WIDTH:0]   rem;
    logic [CW-1:0]    cnt;
    logic [WIDTH+1:0] trial;
    logic             ge;
    logic             neg;
    logic             ovf_c;
    logic [WIDTH-1:0] mag_dvd;
    logic [WIDTH-1:0] mag_dvs;
    logic [WIDTH-1:0] q_c;
    logic [WIDTH-1:0] r_c;

    // operand magnitudes, one restoring step, and sign/saturation of the final result
    always_comb begin
        mag_dvd = bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
        mag_dvs = bus.divisor[WIDTH-1] ? -bus.divisor : bus.divisor;
        trial   = {rem, acc[N-1]};
        ge      = trial >= (WIDTH+2)'(dvs);
        neg     = sign_dvd ^ sign_dvs;
        ovf_c   = neg ? ({1'b0, acc} > LIM) : ({1'b0, acc} >= LIM);
        q_c     = zero ? (sign_dvd ? Q_MIN : Q_MAX) :
                  ovf_c ? (neg ? Q_MIN : Q_MAX) :
                  neg ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        r_c     = zero ? dvd_raw : sign_dvd ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
    end

    // control FSM: latch on open rising edge, iterate N times, then fix signs and publish
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            open_d       <= 1'b0;
            sign_dvd     <= 1'b0;
            sign_dvs     <= 1'b0;
            zero         <= 1'b0;
            dvd_raw      <= '0;
            dvs          <= '0;
            acc          <= '0;
            rem          <= '0;
            cnt          <= '0;
            bus.busy     <= 1'b0;
            bus.finish   <= 1'b0;
            bus.quotient <= '0;
            bus.remainder <= '0;
            bus.div_zero <= 1'b0;
            bus.ovf      <= 1'b0;
        end else begin
            open_d     <= bus.open;
            bus.finish <= 1'b0;
            case (state)
                IDLE: if (bus.open && !open_d) begin
                    sign_dvd <= bus.dividend[WIDTH-1];
                    sign_dvs <= bus.divisor[WIDTH-1];
                    zero     <= bus.divisor == '0;
                    dvd_raw  <= bus.dividend;
                    dvs      <= mag_dvs;
                    acc      <= N'(mag_dvd) << FRAC_BITS;
                    rem      <= '0;
                    cnt      <= '0;
                    bus.busy <= 1'b1;
                    state    <= CALC;
                end
                CALC: begin
                    rem <= ge ? (WIDTH+1)'(trial - (WIDTH+2)'(dvs)) : trial[WIDTH:0];
                    acc <= {acc[N-2:0], ge};
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(N-1)) state <= FIX;
                end
                FIX: begin
                    bus.quotient  <= q_c;
                    bus.remainder <= r_c;
                    bus.div_zero  <= zero;
                    bus.ovf       <= !zero && ovf_c;
                    bus.finish    <= 1'b1;
                    bus.busy      <= 1'b0;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
